// File: rtl/lfsr_engine.sv
// Runtime-configurable Fibonacci/Galois LFSR with valid/ready config loading and lock-up detection.
// Optional period measurement is built only when LFSR_PERIOD_EN is defined.
module lfsr_engine #(
    parameter int               WIDTH        = 10,
    parameter logic [WIDTH-1:0] DEFAULT_POLY = 10'b1001000000,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 10'b1000000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_poly,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic             cfg_galois,
    output logic             cfg_err,
    input  logic             en,
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             lockup,
    output logic             period_wrap,
    output logic [WIDTH-1:0] period_len
);

    // state  | meaning
    // IDLE   | en low, register holds
    // RUN    | stepping once per clock
    // LOCKED | register is all-zero, only a valid config leaves
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LOCKED = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, poly_q, seed_q, next_state;
    logic             galois_q, err_q;
    logic             accept, load, step, next_zero;

    assign cfg_ready = !en || (fsm_q == LOCKED);
    assign accept    = cfg_valid && cfg_ready;
    assign load      = accept && (|cfg_seed);
    assign step      = en && (fsm_q != LOCKED) && !accept;

    always_comb begin
        if (galois_q)
            next_state = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? poly_q : '0);
        else
            next_state = {state_q[WIDTH-2:0], ^(poly_q & state_q)};
    end

    assign next_zero = (next_state == '0);

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (load)
                    fsm_d = IDLE;
                else if (step)
                    fsm_d = next_zero ? LOCKED : RUN;
            end
            RUN: begin
                if (load || !en)
                    fsm_d = IDLE;
                else if (next_zero)
                    fsm_d = LOCKED;
            end
            LOCKED: begin
                if (load)
                    fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            state_q  <= DEFAULT_SEED;
            poly_q   <= DEFAULT_POLY;
            seed_q   <= DEFAULT_SEED;
            galois_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            err_q <= accept && !(|cfg_seed);
            if (load) begin
                state_q  <= cfg_seed;
                poly_q   <= cfg_poly;
                seed_q   <= cfg_seed;
                galois_q <= cfg_galois;
            end else if (step) begin
                state_q <= next_state;
            end
        end
    end

`ifdef LFSR_PERIOD_EN
    logic [WIDTH-1:0] cnt_q, len_q;
    logic             wrap_q;

    // Length is counted in steps, so the wrapping step itself is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            len_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (load) begin
                cnt_q <= '0;
                len_q <= '0;
            end else if (step) begin
                if (next_state == seed_q) begin
                    wrap_q <= 1'b1;
                    len_q  <= cnt_q + 1'b1;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign period_wrap = wrap_q;
    assign period_len  = len_q;
`else
    assign period_wrap = 1'b0;
    assign period_len  = '0;
`endif

    assign state   = state_q;
    assign out_bit = state_q[WIDTH-1];
    assign lockup  = (fsm_q == LOCKED);
    assign cfg_err = err_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Scoreboard bench for lfsr_engine: a 4-bit instance for sequencing/config and a default 10-bit instance.
module tb_lfsr_engine;

`ifdef LFSR_PERIOD_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif

    localparam logic [3:0] D4_POLY  = 4'b1100;
    localparam logic [3:0] D4_SEED  = 4'b1000;
    localparam int         D10_POLY = 10'b1001000000;
    localparam int         D10_SEED = 10'b1000000000;

    logic       clk, rst_n;
    logic       cfg_valid, cfg_galois, en;
    logic [3:0] cfg_poly, cfg_seed;
    logic       cfg_ready, cfg_err, out_bit, lockup, period_wrap;
    logic [3:0] state, period_len;

    logic       cfg_valid10, cfg_galois10, en10;
    logic [9:0] cfg_poly10, cfg_seed10;
    logic       cfg_ready10, cfg_err10, out_bit10, lockup10, period_wrap10;
    logic [9:0] state10, period_len10;

    lfsr_engine #(.WIDTH(4), .DEFAULT_POLY(D4_POLY), .DEFAULT_SEED(D4_SEED)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .cfg_galois(cfg_galois), .cfg_err(cfg_err),
        .en(en), .state(state), .out_bit(out_bit), .lockup(lockup),
        .period_wrap(period_wrap), .period_len(period_len)
    );

    lfsr_engine u_dut10 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid10), .cfg_ready(cfg_ready10),
        .cfg_poly(cfg_poly10), .cfg_seed(cfg_seed10), .cfg_galois(cfg_galois10), .cfg_err(cfg_err10),
        .en(en10), .state(state10), .out_bit(out_bit10), .lockup(lockup10),
        .period_wrap(period_wrap10), .period_len(period_len10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   st;
        logic lk;
        logic err;
        logic wrap;
        logic rdy;
        int   plen;
    } exp_t;

    exp_t q4[$];
    exp_t q10[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: plain integers updated by the rules of the block.
    int m_st, m_poly, m_seed, m_cnt, m_plen;
    bit m_gal, m_lock;
    int n_st, n_cnt, n_plen;
    bit n_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fib_next(input int s, input int p, input int w);
        int fb;
        fb = 0;
        for (int i = 0; i < w; i++)
            fb = fb ^ (((s & p) >> i) & 1);
        return ((s << 1) | fb) & ((1 << w) - 1);
    endfunction

    function automatic int gal_next(input int s, input int p, input int w);
        int r;
        r = (s << 1) & ((1 << w) - 1);
        if (((s >> (w - 1)) & 1) == 1)
            r = r ^ p;
        return r;
    endfunction

    task automatic model_reset();
        m_st = D4_SEED; m_poly = D4_POLY; m_seed = D4_SEED; m_gal = 1'b0;
        m_lock = 1'b0; m_cnt = 0; m_plen = 0;
        n_st = D10_SEED; n_cnt = 0; n_plen = 0; n_lock = 1'b0;
    endtask

    // Drives one cycle of inputs and queues what both instances must show after the next edge.
    task automatic tick(input logic e, input logic v, input logic [3:0] p, input logic [3:0] s,
                        input logic g, input logic e10);
        exp_t x, y;
        int   nx;
        bit   acc;
        @(negedge clk);
        #1;
        en = e; cfg_valid = v; cfg_poly = p; cfg_seed = s; cfg_galois = g; en10 = e10;

        x.err = 1'b0; x.wrap = 1'b0;
        acc = v && (!e || m_lock);
        if (acc) begin
            if (s == 4'd0) begin
                x.err = 1'b1;
            end else begin
                m_st = int'(s); m_poly = int'(p); m_seed = int'(s); m_gal = g;
                m_lock = 1'b0; m_cnt = 0; m_plen = 0;
            end
        end else if (e && !m_lock) begin
            nx = m_gal ? gal_next(m_st, m_poly, 4) : fib_next(m_st, m_poly, 4);
            m_st = nx;
            if (nx == 0) m_lock = 1'b1;
            if (PER) begin
                m_cnt = (m_cnt + 1) % 16;
                if (nx == m_seed) begin
                    x.wrap = 1'b1;
                    m_plen = m_cnt;
                    m_cnt  = 0;
                end
            end
        end
        x.st = m_st; x.lk = m_lock; x.plen = m_plen; x.rdy = !e || m_lock;
        q4.push_back(x);

        y.err = 1'b0; y.wrap = 1'b0;
        if (e10 && !n_lock) begin
            nx = fib_next(n_st, D10_POLY, 10);
            n_st = nx;
            if (nx == 0) n_lock = 1'b1;
            if (PER) begin
                n_cnt = (n_cnt + 1) % 1024;
                if (nx == D10_SEED) begin
                    y.wrap = 1'b1;
                    n_plen = n_cnt;
                    n_cnt  = 0;
                end
            end
        end
        y.st = n_st; y.lk = n_lock; y.plen = n_plen; y.rdy = !e10 || n_lock;
        q10.push_back(y);
    endtask

    // Reset lands between edges; outputs must change before any clock edge arrives.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_state4", 32'(state), 32'(D4_SEED));
        chk("async_plen4", 32'(period_len), 32'd0);
        chk("async_lockup4", 32'(lockup), 32'd0);
        chk("async_state10", 32'(state10), 32'(D10_SEED));
        chk("async_plen10", 32'(period_len10), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    exp_t e4, e10;
    always @(negedge clk) begin
        if (q4.size() > 0) begin
            e4 = q4.pop_front();
            chk("state4", 32'(state), 32'(e4.st));
            chk("out_bit4", 32'(out_bit), 32'((e4.st >> 3) & 1));
            chk("lockup4", 32'(lockup), 32'(e4.lk));
            chk("cfg_err4", 32'(cfg_err), 32'(e4.err));
            chk("wrap4", 32'(period_wrap), 32'(e4.wrap));
            chk("plen4", 32'(period_len), 32'(e4.plen));
            chk("ready4", 32'(cfg_ready), 32'(e4.rdy));
        end
        if (q10.size() > 0) begin
            e10 = q10.pop_front();
            chk("state10", 32'(state10), 32'(e10.st));
            chk("lockup10", 32'(lockup10), 32'(e10.lk));
            chk("cfg_err10", 32'(cfg_err10), 32'(e10.err));
            chk("wrap10", 32'(period_wrap10), 32'(e10.wrap));
            chk("plen10", 32'(period_len10), 32'(e10.plen));
            chk("ready10", 32'(cfg_ready10), 32'(e10.rdy));
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_poly = '0; cfg_seed = '0; cfg_galois = 1'b0;
        en10 = 1'b0; cfg_valid10 = 1'b0; cfg_poly10 = 10'h3FF; cfg_seed10 = 10'h001; cfg_galois10 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset, then free-run the default 10-bit generator.
        repeat (5) tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        repeat (25) tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Fibonacci and Galois maximal sequences, a few steps past the wrap.
        tick(1'b0, 1'b1, 4'b1100, 4'b0001, 1'b0, 1'b0);
        repeat (17) tick(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b1, 1'b0);
        repeat (17) tick(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Drain to zero with an empty tap mask, then recover while en stays high.
        tick(1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0);
        repeat (7) tick(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 4'b1100, 4'b0101, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Zero seed rejected, then a config offered while stepping waits for en low.
        tick(1'b0, 1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b1, 4'b0011, 4'b0110, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 4'b0011, 4'b0110, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Reset mid-run with a config pending, which is taken after release.
        tick(1'b0, 1'b1, 4'b1001, 4'b0111, 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b1, 4'b1001, 4'b0011, 1'b0, 1'b1);
        do_reset();
        tick(1'b0, 1'b1, 4'b1001, 4'b0011, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 4'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                 $urandom_range(0, 1) == 1);
        end
        tick(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

        @(negedge clk);
        #2;
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q10_drained", 32'(q10.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
